ls74283_seq: RTL and testbench
==============================

Name: ls74283_seq

Overview:
- Multi-cycle controller that sequences one ls74283 4-bit adder instance to add or subtract N-nibble operands, one nibble per clock, LSB nibble first.
- Nibble carry is held in a register between nibbles.
- Serves as the ALU add/sub path of the WIMS CPU datapath: one adder chip is reused over several cycles instead of cascading N chips.
- Uses a start/ready/done handshake toward the control unit.

Parameters:
- NIBBLES, 4, number of 4-bit nibbles per operand; operand width W = 4*NIBBLES; legal range 2..8.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when ready=1.
- sub  input  1  0 = A+B, 1 = A-B; sampled with start.
- op_a  input  W  operand A; sampled with start.
- op_b  input  W  operand B; sampled with start.
- ready  output  1  high in IDLE only.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse; result and flags valid.
- result  output  W  sum/difference; held until the next accepted start.
- cout  output  1  carry out of MSB nibble; for sub, 1 = no borrow.
- ovf  output  1  two's-complement signed overflow.
- zero  output  1  result == 0.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, nibble index=0, carry reg=0.
  - result=0, cout=0, ovf=0, zero=0, done=0, busy=0, ready=1.
  - Reset mid-operation aborts immediately; no partial result is retained.
- States: IDLE, RUN, DONE.
- IDLE, on edge with start=1:
  - Latch op_a into A reg.
  - Latch B reg = sub ? ~op_b : op_b.
  - carry reg = sub; idx=0; clear result reg; go to RUN.
  - start=0: remain in IDLE.
- RUN, each edge:
  - Adder inputs a=A[4*idx+:4], b=B[4*idx+:4], cin=carry reg (combinational through ls74283).
  - result[4*idx+:4] <= sum; carry reg <= adder cout; idx <= idx+1.
  - When idx==NIBBLES-1: capture final carry into cout, compute ovf and zero, go to DONE.
- DONE: done=1 for exactly one cycle, then unconditionally IDLE. start during DONE is ignored.
- Latency: start sampled at edge T0; done high during the cycle after edge T0+NIBBLES; ready returns after edge T0+NIBBLES+1. Throughput is one operation per NIBBLES+2 cycles.
- ovf = (A[W-1] == B[W-1]) && (result[W-1] != A[W-1]), using the post-inversion B reg.
- zero is computed on the full final result.
- start while busy or in DONE: ignored; latched operands are unaffected by input changes during RUN.
- No intermediate result bits are guaranteed stable while busy=1; consumers read only when done=1 or in IDLE afterward.
- Flags and result hold their last values through IDLE until the next accepted start clears result.
- Wrap-around: W-bit modular arithmetic; carry beyond the MSB appears only on cout.

Test Plan (NIBBLES=4):
- Add: reset, start with sub=0, A=0x1234, B=0x4321 -> done exactly 4 cycles after the start edge; result=0x5555, cout=0, ovf=0, zero=0; ready high one cycle later.
- Full carry ripple: A=0xFFFF, B=0x0001, sub=0 -> result=0x0000, cout=1, zero=1, ovf=0 (carry propagates through all nibbles).
- Subtract with borrow: A=0x0005, B=0x0007, sub=1 -> result=0xFFFE, cout=0, ovf=0. Then A=0x0007, B=0x0005, sub=1 -> 0x0002, cout=1.
- Signed overflow: A=0x7FFF, B=0x0001, sub=0 -> 0x8000, ovf=1, cout=0. A=0x8000, B=0x0001, sub=1 -> 0x7FFF, ovf=1, cout=1.
- Handshake abuse: start with A=0x1111, B=0x1111. Pulse start with A=0xAAAA while busy, and again during the done cycle -> result=0x2222, exactly one done pulse, no second operation.
- Reset mid-op: assert rst_n=0 for one cycle during RUN at idx=2 -> outputs zero immediately, ready=1, no done pulse. A following operation 0x0F0F+0x00F1 -> 0x1000, cout=0.

Source files
------------

// File: rtl/ls74283_seq_if.sv
// rtl/ls74283_seq_if.sv - control-unit bus for the nibble-serial add/sub sequencer
interface ls74283_seq_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         start;
    logic         sub;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;
    logic         zero;

    modport master (
        output start, sub, op_a, op_b,
        input  ready, busy, done, result, cout, ovf, zero
    );

    modport slave (
        input  start, sub, op_a, op_b,
        output ready, busy, done, result, cout, ovf, zero
    );
endinterface

// File: rtl/ls74283_seq.sv
// rtl/ls74283_seq.sv - one ls74283 adder reused nibble by nibble for N-nibble add/sub
module ls74283 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    // 4-bit full adder with carry in/out, behaving like the TTL part
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
endmodule

module ls74283_seq #(
    parameter int NIBBLES = 4
) (
    input logic              clk,
    input logic              rst_n,
    ls74283_seq_if.slave     bus
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state;
    logic [IW-1:0] idx;
    logic          carry;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [W-1:0]  result_q;
    logic          cout_q;
    logic          ovf_q;
    logic          zero_q;

    logic [3:0]    add_a;
    logic [3:0]    add_b;
    logic [3:0]    add_sum;
    logic          add_cout;
    logic          last;
    logic [W-1:0]  result_nx;

    // B is stored already inverted for subtraction, so the adder only ever adds
    assign add_a = a_q[4*idx +: 4];
    assign add_b = b_q[4*idx +: 4];
    assign last  = (idx == IW'(NIBBLES - 1));

    ls74283 u_add (
        .a    (add_a),
        .b    (add_b),
        .cin  (carry),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Result as it will look once the current nibble is written; flags on the
    // final nibble are derived from this so they see the complete word
    always_comb begin
        result_nx = result_q;
        result_nx[4*idx +: 4] = add_sum;
    end

    // Sequencer: latch operands, ripple one nibble per clock, pulse done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            idx      <= '0;
            carry    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        a_q      <= bus.op_a;
                        b_q      <= bus.sub ? ~bus.op_b : bus.op_b;
                        carry    <= bus.sub;
                        idx      <= '0;
                        result_q <= '0;
                        state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    result_q <= result_nx;
                    carry    <= add_cout;
                    if (last) begin
                        idx    <= '0;
                        cout_q <= add_cout;
                        ovf_q  <= (a_q[W-1] == b_q[W-1]) && (result_nx[W-1] != a_q[W-1]);
                        zero_q <= (result_nx == '0);
                        state  <= S_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ready  = (state == S_IDLE);
    assign bus.busy   = (state == S_RUN);
    assign bus.done   = (state == S_DONE);
    assign bus.result = result_q;
    assign bus.cout   = cout_q;
    assign bus.ovf    = ovf_q;
    assign bus.zero   = zero_q;
endmodule

// File: tb/tb_ls74283_seq.sv
// tb/tb_ls74283_seq.sv - directed bench with arithmetic reference model
module tb_ls74283_seq;
    localparam int N = 4;
    localparam int W = 4 * N;

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;
    int   done_seen = 0;

    ls74283_seq_if #(.NIBBLES(N)) bus_if ();

    ls74283_seq #(.NIBBLES(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: whole-word arithmetic, result published NIBBLES edges after acceptance
    int           m_left = 0;
    logic [W-1:0] p_res;
    logic         p_cout, p_ovf, p_zero;
    logic [W-1:0] e_res = '0;
    logic         e_cout = 1'b0, e_ovf = 1'b0, e_zero = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        logic [W:0]   full;
        logic [W-1:0] bb;
        if (!rst_n) begin
            m_left = 0;
            e_res  = '0;
            e_cout = 1'b0;
            e_ovf  = 1'b0;
            e_zero = 1'b0;
        end else if (m_left == 0) begin
            if (bus_if.start) begin
                bb     = bus_if.sub ? ~bus_if.op_b : bus_if.op_b;
                full   = {1'b0, bus_if.op_a} + {1'b0, bb} + (W+1)'(bus_if.sub);
                p_res  = full[W-1:0];
                p_cout = full[W];
                p_ovf  = (bus_if.op_a[W-1] == bb[W-1]) && (p_res[W-1] != bus_if.op_a[W-1]);
                p_zero = (p_res == '0);
                e_res  = '0;
                m_left = N + 1;
            end
        end else begin
            m_left--;
            if (m_left == 1) begin
                e_res  = p_res;
                e_cout = p_cout;
                e_ovf  = p_ovf;
                e_zero = p_zero;
            end
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        chk("ready", 32'(bus_if.ready), 32'(m_left == 0));
        chk("busy",  32'(bus_if.busy),  32'(m_left > 1));
        chk("done",  32'(bus_if.done),  32'(m_left == 1));
        if (m_left <= 1) begin
            chk("result", 32'(bus_if.result), 32'(e_res));
            chk("cout",   32'(bus_if.cout),   32'(e_cout));
            chk("ovf",    32'(bus_if.ovf),    32'(e_ovf));
            chk("zero",   32'(bus_if.zero),   32'(e_zero));
        end
        if (bus_if.done) done_seen++;
    end

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input logic [W-1:0] er, input logic ec, input logic eo, input logic ez);
        int k;
        @(posedge clk); #2;
        bus_if.start = 1'b1; bus_if.op_a = a; bus_if.op_b = b; bus_if.sub = s;
        @(posedge clk); #2;
        bus_if.start = 1'b0;
        for (k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (bus_if.done) break;
        end
        chk("lit_latency", 32'(k), 32'(N));
        chk("lit_result",  32'(bus_if.result), 32'(er));
        chk("lit_cout",    32'(bus_if.cout), 32'(ec));
        chk("lit_ovf",     32'(bus_if.ovf), 32'(eo));
        chk("lit_zero",    32'(bus_if.zero), 32'(ez));
        @(posedge clk); #1;
        chk("lit_ready_after", 32'(bus_if.ready), 32'd1);
    endtask

    initial begin
        int k;
        rst_n = 1'b0;
        bus_if.start = 1'b0; bus_if.sub = 1'b0;
        bus_if.op_a = '0; bus_if.op_b = '0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("lit_reset_result", 32'(bus_if.result), 32'd0);
        chk("lit_reset_ready",  32'(bus_if.ready), 32'd1);

        run_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        run_op(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        run_op(16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        run_op(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);

        // Start pulses while busy and during done must be ignored
        done_seen = 0;
        @(posedge clk); #2;
        bus_if.start = 1'b1; bus_if.op_a = 16'h1111; bus_if.op_b = 16'h1111; bus_if.sub = 1'b0;
        @(posedge clk); #2;
        bus_if.start = 1'b0;
        @(posedge clk); #2;
        bus_if.start = 1'b1; bus_if.op_a = 16'hAAAA;
        @(posedge clk); #2;
        bus_if.start = 1'b0; bus_if.op_a = 16'h0000;
        for (k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (bus_if.done) break;
        end
        chk("abuse_done_seen", 32'(bus_if.done), 32'd1);
        chk("abuse_result", 32'(bus_if.result), 32'h2222);
        #1;
        bus_if.start = 1'b1; bus_if.op_a = 16'hAAAA;
        @(posedge clk); #2;
        bus_if.start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("abuse_hold_result", 32'(bus_if.result), 32'h2222);
        chk("abuse_done_count", 32'(done_seen), 32'd1);

        // Reset in the middle of an operation
        done_seen = 0;
        @(posedge clk); #2;
        bus_if.start = 1'b1; bus_if.op_a = 16'h1234; bus_if.op_b = 16'h1111;
        @(posedge clk); #2;
        bus_if.start = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_ready",  32'(bus_if.ready), 32'd1);
        chk("midrst_busy",   32'(bus_if.busy), 32'd0);
        chk("midrst_result", 32'(bus_if.result), 32'd0);
        @(posedge clk); #2 rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("midrst_no_done", 32'(done_seen), 32'd0);
        run_op(16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
